// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single SDRAM controller slave.
// Grants are sticky and round-robin under contention. The granted master's
// command reaches the slave combinationally, and a small tag FIFO records
// which master issued each accepted read so returning data can be routed
// back in order.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_PENDING = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              rd_err
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

    typedef enum logic {G0 = 1'b0, G1 = 1'b1} grant_e;

    grant_e grant_q, grant_d;

    // Tag FIFO state: one master-ID bit per outstanding read.
    logic             tag_mem_q [MAX_PENDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_err_q, rd_err_d;

    // Master-side signals gathered into arrays so they can be indexed by grant.
    logic [ADDR_W-1:0] m_address    [2];
    logic              m_read       [2];
    logic              m_write      [2];
    logic [DATA_W-1:0] m_writedata  [2];
    logic [BE_W-1:0]   m_byteenable [2];
    logic              m_wait       [2];
    logic              m_rdv        [2];

    assign m_address[0]    = m0_address;
    assign m_address[1]    = m1_address;
    assign m_read[0]       = m0_read;
    assign m_read[1]       = m1_read;
    assign m_write[0]      = m0_write;
    assign m_write[1]      = m1_write;
    assign m_writedata[0]  = m0_writedata;
    assign m_writedata[1]  = m1_writedata;
    assign m_byteenable[0] = m0_byteenable;
    assign m_byteenable[1] = m1_byteenable;

    logic gsel;
    logic g_read, g_write;
    logic fifo_full, fifo_empty;
    logic read_eff, read_blocked;
    logic accept, push, pop;
    logic head_id;
    logic other_req, x_presenting;

    assign gsel       = (grant_q == G1);
    assign g_read     = m_read[gsel];
    assign g_write    = m_write[gsel];
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // A simultaneous read+write is treated as a write; the read is ignored.
    assign read_eff     = g_read && !g_write && !fifo_full;
    assign read_blocked = g_read && !g_write && fifo_full;
    assign accept       = (g_write || read_eff) && !s_waitrequest;
    assign push         = read_eff && !s_waitrequest;
    assign pop          = s_readdatavalid && !fifo_empty;
    assign head_id      = tag_mem_q[rd_ptr_q];

    assign s_address    = m_address[gsel];
    assign s_read       = read_eff;
    assign s_write      = g_write;
    assign s_writedata  = m_writedata[gsel];
    assign s_byteenable = m_byteenable[gsel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            // Non-granted master always stalls; granted one stalls on slave or a full FIFO.
            assign m_wait[gi] = (gsel != 1'(gi)) ? 1'b1 : (s_waitrequest || read_blocked);
            assign m_rdv[gi]  = pop && (head_id == 1'(gi));
        end
    endgenerate

    assign m0_waitrequest   = m_wait[0];
    assign m1_waitrequest   = m_wait[1];
    assign m0_readdatavalid = m_rdv[0];
    assign m1_readdatavalid = m_rdv[1];
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign rd_err           = rd_err_q;

    // Hand the grant over only when the holder is done or idle, never mid-stall.
    always_comb begin
        grant_d      = grant_q;
        other_req    = m_read[~gsel] || m_write[~gsel];
        x_presenting = g_write || (g_read && !fifo_full);
        if (other_req && (accept || !x_presenting)) begin
            grant_d = (grant_q == G0) ? G1 : G0;
        end
    end

    // Next-state for FIFO pointers, occupancy and the sticky error flag.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rd_err_d = rd_err_q || (s_readdatavalid && fifo_empty);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q  <= G0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_err_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Tag storage; entries are only meaningful between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gsel;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int BE_W        = 2;
    localparam int MAX_PENDING = 8;
    localparam int VW          = ADDR_W + 3 * DATA_W + BE_W + 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_read, m1_read, m0_write, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic              s_read, s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic              rd_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .rd_err(rd_err)
    );

    // ---------------- behavioural model ----------------
    int mdl_grant;          // which master currently owns the slave
    int mdl_tags[$];        // issuing master of each outstanding read, oldest first
    bit mdl_rd_err;

    function automatic void mdl_reset();
        mdl_grant  = 0;
        mdl_tags   = {};
        mdl_rd_err = 1'b0;
    endfunction

    function automatic bit mdl_full();
        return mdl_tags.size() >= MAX_PENDING;
    endfunction

    function automatic bit req_read(int n);
        return (n == 0) ? m0_read : m1_read;
    endfunction

    function automatic bit req_write(int n);
        return (n == 0) ? m0_write : m1_write;
    endfunction

    function automatic logic [VW-1:0] mdl_expect();
        int g;
        bit gr, gw, reff, w0, w1, v0, v1;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd;
        logic [BE_W-1:0]   gb;
        g    = mdl_grant;
        gr   = req_read(g);
        gw   = req_write(g);
        reff = gr && !gw && !mdl_full();
        ga   = (g == 0) ? m0_address    : m1_address;
        gd   = (g == 0) ? m0_writedata  : m1_writedata;
        gb   = (g == 0) ? m0_byteenable : m1_byteenable;
        w0   = (g != 0) ? 1'b1 : (s_waitrequest || (m0_read && !m0_write && mdl_full()));
        w1   = (g != 1) ? 1'b1 : (s_waitrequest || (m1_read && !m1_write && mdl_full()));
        v0   = s_readdatavalid && (mdl_tags.size() > 0) && (mdl_tags[0] == 0);
        v1   = s_readdatavalid && (mdl_tags.size() > 0) && (mdl_tags[0] == 1);
        return {ga, reff, gw, gd, gb, w0, w1, v0, v1, s_readdata, s_readdata, mdl_rd_err};
    endfunction

    function automatic void mdl_step();
        int g;
        bit gr, gw, reff, acc, full, ypres, xpres;
        if (!reset_n) begin
            mdl_reset();
            return;
        end
        g     = mdl_grant;
        gr    = req_read(g);
        gw    = req_write(g);
        full  = mdl_full();
        reff  = gr && !gw && !full;
        acc   = (gw || reff) && !s_waitrequest;
        ypres = req_read(1 - g) || req_write(1 - g);
        xpres = gw || (gr && !full);
        if (s_readdatavalid) begin
            if (mdl_tags.size() > 0) void'(mdl_tags.pop_front());
            else mdl_rd_err = 1'b1;
        end
        if (reff && !s_waitrequest) mdl_tags.push_back(g);
        if (ypres && (acc || !xpres)) mdl_grant = 1 - g;
    endfunction

    logic [VW-1:0] dut_vec;
    assign dut_vec = {s_address, s_read, s_write, s_writedata, s_byteenable,
                      m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
                      m0_readdata, m1_readdata, rd_err};

    // Advance the model over the coming rising edge and move to the next falling edge.
    task automatic tick();
        mdl_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_waitrequest = 0; s_readdatavalid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        mdl_reset();
        m0_address = 25'h0ABCDE; m0_writedata = 16'h1234; m0_byteenable = 2'b01;
        m1_address = 25'h1FFFFF; m1_writedata = 16'hBEEF; m1_byteenable = 2'b10;
        #1;
        checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
        checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL reset_m0_wait: got %b want 0", m0_waitrequest); end
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin failures++; $display("FAIL reset_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
        checks++; if ({s_address, s_writedata, s_byteenable} !== {25'h0ABCDE, 16'h1234, 2'b01}) begin failures++; $display("FAIL reset_s_follows_m0: got %h/%h/%b want 0abcde/1234/01", s_address, s_writedata, s_byteenable); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        logic [DATA_W-1:0] d;
        d = DATA_W'($urandom);
        m0_read = 1; m0_address = 25'h10;
        #1;
        checks++; if ({s_read, s_address, m0_waitrequest} !== {1'b1, 25'h10, 1'b0}) begin failures++; $display("FAIL single_issue: got rd=%b addr=%h wait=%b want rd=1 addr=10 wait=0", s_read, s_address, m0_waitrequest); end
        tick();
        m0_read = 0;
        #1; tick();
        s_readdatavalid = 1; s_readdata = d;
        #1;
        checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) begin failures++; $display("FAIL single_rdv: got m0=%b m1=%b want m0=1 m1=0", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (m0_readdata !== d) begin failures++; $display("FAIL single_data: got %h want %h", m0_readdata, d); end
        tick();
        s_readdatavalid = 0;
        $display("test_single_read done data=%h", d);
    endtask

    task automatic test_back_to_back();
        int idx0 = 0, idx1 = 0, st0 = 0, st1 = 0, maxst = 0, n0 = 0, n1 = 0;
        logic [DATA_W-1:0] want_d;
        for (int k = 0; k < 8; k++) begin
            m0_write = 1; m0_address = {1'b0, 24'(idx0)}; m0_writedata = DATA_W'($urandom);
            m1_write = 1; m1_address = {1'b1, 24'(idx1)}; m1_writedata = DATA_W'($urandom);
            #1;
            want_d = (k % 2 == 1) ? m1_writedata : m0_writedata;
            checks++; if ({s_write, s_address[ADDR_W-1]} !== {1'b1, 1'(k % 2)}) begin failures++; $display("FAIL b2b_owner[%0d]: got wr=%b master=%0d want wr=1 master=%0d", k, s_write, s_address[ADDR_W-1], k % 2); end
            checks++; if (s_writedata !== want_d) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", k, s_writedata, want_d); end
            if (!m0_waitrequest) begin idx0++; n0++; st0 = 0; end else st0++;
            if (!m1_waitrequest) begin idx1++; n1++; st1 = 0; end else st1++;
            if (st0 > maxst) maxst = st0;
            if (st1 > maxst) maxst = st1;
            tick();
        end
        m0_write = 0; m1_write = 0;
        checks++; if (n0 != 4 || n1 != 4) begin failures++; $display("FAIL b2b_counts: got m0=%0d m1=%0d want 4/4", n0, n1); end
        checks++; if (maxst > 1) begin failures++; $display("FAIL b2b_max_stall: got %0d want <=1", maxst); end
        $display("test_back_to_back done m0=%0d m1=%0d max_stall=%0d", n0, n1, maxst);
    endtask

    task automatic test_hold();
        logic [ADDR_W-1:0] a, b;
        logic [DATA_W-1:0] d;
        a = ADDR_W'($urandom); b = ADDR_W'($urandom); d = DATA_W'($urandom);
        m0_write = 1; m0_address = a; m0_writedata = d;
        m1_write = 1; m1_address = b; m1_writedata = ~d;
        s_waitrequest = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({s_address, s_writedata, m0_waitrequest, m1_waitrequest} !== {a, d, 1'b1, 1'b1}) begin failures++; $display("FAIL hold_stall[%0d]: got addr=%h data=%h w0=%b w1=%b want addr=%h data=%h w0=1 w1=1", k, s_address, s_writedata, m0_waitrequest, m1_waitrequest, a, d); end
            tick();
        end
        s_waitrequest = 0;
        #1;
        checks++; if ({s_address, m0_waitrequest, m1_waitrequest} !== {a, 1'b0, 1'b1}) begin failures++; $display("FAIL hold_accept: got addr=%h w0=%b w1=%b want addr=%h w0=0 w1=1", s_address, m0_waitrequest, m1_waitrequest, a); end
        tick();
        m0_write = 0;
        #1;
        checks++; if ({s_address, s_writedata, m1_waitrequest} !== {b, ~d, 1'b0}) begin failures++; $display("FAIL hold_switch: got addr=%h data=%h w1=%b want addr=%h data=%h w1=0", s_address, s_writedata, m1_waitrequest, b, ~d); end
        tick();
        m1_write = 0;
        $display("test_hold done addr=%h", a);
    endtask

    task automatic test_fifo_full();
        logic [ADDR_W-1:0] c;
        c = 25'h0C0DE;
        m1_read = 1;
        for (int i = 0; i < MAX_PENDING; i++) begin
            m1_address = ADDR_W'(i);
            #1;
            checks++; if ({m1_waitrequest, s_read} !== 2'b01) begin failures++; $display("FAIL full_accept[%0d]: got wait=%b rd=%b want wait=0 rd=1", i, m1_waitrequest, s_read); end
            tick();
        end
        m1_address = ADDR_W'(MAX_PENDING);
        m0_write = 1; m0_address = c;
        #1;
        checks++; if ({m1_waitrequest, s_read, m0_waitrequest} !== 3'b101) begin failures++; $display("FAIL full_block: got w1=%b rd=%b w0=%b want w1=1 rd=0 w0=1", m1_waitrequest, s_read, m0_waitrequest); end
        tick();
        #1;
        checks++; if ({s_write, s_address, m0_waitrequest, m1_waitrequest} !== {1'b1, c, 1'b0, 1'b1}) begin failures++; $display("FAIL full_m0_write: got wr=%b addr=%h w0=%b w1=%b want wr=1 addr=%h w0=0 w1=1", s_write, s_address, m0_waitrequest, m1_waitrequest, c); end
        tick();
        m0_write = 0;
        s_readdatavalid = 1; s_readdata = 16'h5A5A;
        #1;
        checks++; if ({m1_readdatavalid, m0_readdatavalid, m1_waitrequest} !== 3'b101) begin failures++; $display("FAIL full_pop: got v1=%b v0=%b w1=%b want v1=1 v0=0 w1=1", m1_readdatavalid, m0_readdatavalid, m1_waitrequest); end
        tick();
        s_readdatavalid = 0;
        #1;
        checks++; if ({m1_waitrequest, s_read} !== 2'b01) begin failures++; $display("FAIL full_ninth: got wait=%b rd=%b want wait=0 rd=1", m1_waitrequest, s_read); end
        tick();
        m1_address = ADDR_W'(MAX_PENDING + 1);
        #1;
        checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL full_tenth: got wait=%b want 1", m1_waitrequest); end
        tick();
        m1_read = 0;
        for (int i = 0; i < MAX_PENDING; i++) begin
            s_readdatavalid = 1;
            #1;
            checks++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) begin failures++; $display("FAIL full_drain[%0d]: got v1=%b v0=%b want v1=1 v0=0", i, m1_readdatavalid, m0_readdatavalid); end
            tick();
        end
        s_readdatavalid = 0;
        $display("test_fifo_full done");
    endtask

    task automatic test_interleave();
        int seq [3] = '{0, 1, 0};
        int route [4] = '{0, 1, 0, 0};
        logic [DATA_W-1:0] d;
        bit done;
        for (int s = 0; s < 3; s++) begin
            done = 0;
            if (seq[s] == 0) begin m0_read = 1; m0_address = ADDR_W'(32 + s); end
            else begin m1_read = 1; m1_address = ADDR_W'(32 + s); end
            for (int t = 0; t < 4 && !done; t++) begin
                #1;
                if (((seq[s] == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1;
                tick();
            end
            m0_read = 0; m1_read = 0;
            checks++; if (!done) begin failures++; $display("FAIL inter_issue[%0d]: read from m%0d got no accept within 4 cycles, want accepted", s, seq[s]); end
        end
        // First return coincides with a new m0 read: occupancy stays at 3.
        for (int p = 0; p < 4; p++) begin
            d = DATA_W'($urandom);
            s_readdatavalid = 1; s_readdata = d;
            m0_read = (p == 0); m0_address = 25'h77;
            #1;
            checks++; if ({m0_readdatavalid, m1_readdatavalid} !== ((route[p] == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL inter_route[%0d]: got v0=%b v1=%b want m%0d", p, m0_readdatavalid, m1_readdatavalid, route[p]); end
            checks++; if (((route[p] == 0) ? m0_readdata : m1_readdata) !== d) begin failures++; $display("FAIL inter_data[%0d]: got %h want %h", p, (route[p] == 0) ? m0_readdata : m1_readdata, d); end
            if (p == 0) begin
                checks++; if ({s_read, m0_waitrequest} !== 2'b10) begin failures++; $display("FAIL inter_push_pop: got rd=%b w0=%b want rd=1 w0=0", s_read, m0_waitrequest); end
            end
            tick();
        end
        m0_read = 0; s_readdatavalid = 0;
        $display("test_interleave done");
    endtask

    task automatic test_rd_err();
        s_readdatavalid = 1;
        #1;
        checks++; if ({m0_readdatavalid, m1_readdatavalid, rd_err} !== 3'b000) begin failures++; $display("FAIL err_empty_pulse: got v0=%b v1=%b err=%b want 000", m0_readdatavalid, m1_readdatavalid, rd_err); end
        tick();
        s_readdatavalid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL err_sticky[%0d]: got %b want 1", k, rd_err); end
            tick();
        end
        reset_n = 0;
        mdl_reset();
        #1;
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL err_reset_clear: got %b want 0", rd_err); end
        tick();
        reset_n = 1;
        tick();
        $display("test_rd_err done");
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_vec;
        int bad = 0;
        for (int k = 0; k < 600; k++) begin
            reset_n         = ($urandom_range(0, 249) != 0);
            m0_read         = ($urandom_range(0, 2) == 0);
            m0_write        = ($urandom_range(0, 3) == 0);
            m1_read         = ($urandom_range(0, 2) == 0);
            m1_write        = ($urandom_range(0, 3) == 0);
            m0_address      = ADDR_W'($urandom);
            m1_address      = ADDR_W'($urandom);
            m0_writedata    = DATA_W'($urandom);
            m1_writedata    = DATA_W'($urandom);
            m0_byteenable   = BE_W'($urandom);
            m1_byteenable   = BE_W'($urandom);
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            s_readdatavalid = ((mdl_tags.size() > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 127) == 0);
            s_readdata      = DATA_W'($urandom);
            if (!reset_n) mdl_reset();
            #1;
            exp_vec = mdl_expect();
            checks++; if (dut_vec !== exp_vec) begin failures++; bad++; $display("FAIL random[%0d]: got %h want %h", k, dut_vec, exp_vec); end
            tick();
        end
        idle_inputs();
        reset_n = 1;
        $display("test_random done cycles=600 mismatches=%0d", bad);
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = '0; m1_byteenable = '0; s_readdata = '0;
        mdl_reset();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hold();
        test_fifo_full();
        test_interleave();
        test_rd_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
